// File: rtl/alu_commit_stage.sv
// In-order commit stage for ALU results: small FIFO, architectural NZCV register,
// per-entry condition evaluation and a valid/ready register-file write port.
module alu_commit_stage #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_y,
  input  logic [3:0]   in_nzcv,
  input  logic [4:0]   in_rd,
  input  logic         in_we,
  input  logic         in_setf,
  input  logic [3:0]   in_cond,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [4:0]   wb_rd,
  output logic [W-1:0] wb_data,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   nzcv;
    logic [4:0]   rd;
    logic         we;
    logic         setf;
    logic [3:0]   cond;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3:0]     flags_q, flags_d;

  entry_t         in_entry;
  entry_t         head;
  logic           push;
  logic           pop;
  logic           pass;

  // Flags arrive as {N,Z,C,V}; codes follow the usual ARM-style condition table.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c && !z;
      4'd9:    cond_eval = !c || z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z && (n == v);
      4'd13:   cond_eval = z || (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign in_entry = '{y: in_y, nzcv: in_nzcv, rd: in_rd, we: in_we, setf: in_setf, cond: in_cond};
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    busy     = (count_q != '0);
    push     = in_valid && in_ready;
    pass     = cond_eval(head.cond, flags_q);
    wb_valid = busy && pass && head.we;
    wb_rd    = wb_valid ? head.rd : 5'd0;
    wb_data  = wb_valid ? head.y : '0;
    // Dropped and non-writing entries never wait on the register file.
    pop      = busy && (!pass || !head.we || wb_ready);
    flags    = flags_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop && pass && head.setf) flags_d = head.nzcv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  // Payload storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_alu_commit_stage.sv
// Self-checking bench for alu_commit_stage: directed scenarios plus random stress,
// all compared each cycle against a queue-based reference model.
module tb_alu_commit_stage;

  localparam int DEPTH = 2;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_y;
  logic [3:0]   in_nzcv;
  logic [4:0]   in_rd;
  logic         in_we;
  logic         in_setf;
  logic [3:0]   in_cond;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic [3:0]   flags;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   nzcv;
    logic [4:0]   rd;
    logic         we;
    logic         setf;
    logic [3:0]   cond;
  } ent_t;

  ent_t       model_q[$];
  logic [3:0] model_flags;
  int         writes_seen;

  alu_commit_stage #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_y     (in_y),
    .in_nzcv  (in_nzcv),
    .in_rd    (in_rd),
    .in_we    (in_we),
    .in_setf  (in_setf),
    .in_cond  (in_cond),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flags    (flags),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Condition truth: even codes 0..12 test a base predicate, the following odd code negates it.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'd14) return 1'b1;
    if (cond == 4'd15) return 1'b0;
    case (cond >> 1)
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n ~^ v);
      default: base = ~z & (n ~^ v);
    endcase
    return cond[0] ? ~base : base;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic exp_busy, exp_wbv;
    logic [4:0] exp_rd;
    logic [W-1:0] exp_data;
    exp_busy = (model_q.size() != 0);
    exp_wbv  = 1'b0;
    exp_rd   = 5'd0;
    exp_data = '0;
    if (exp_busy && model_q[0].we && model_cond(model_q[0].cond, model_flags)) begin
      exp_wbv  = 1'b1;
      exp_rd   = model_q[0].rd;
      exp_data = model_q[0].y;
    end
    checkOutput("in_ready", W'(in_ready), W'(model_q.size() < DEPTH));
    checkOutput("busy",     W'(busy),     W'(exp_busy));
    checkOutput("wb_valid", W'(wb_valid), W'(exp_wbv));
    checkOutput("wb_rd",    W'(wb_rd),    W'(exp_rd));
    checkOutput("wb_data",  wb_data,      exp_data);
    checkOutput("flags",    W'(flags),    W'(model_flags));
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model on the rising edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] y, input logic [3:0] nzcv,
                               input logic [4:0] rd, input logic we, input logic setf,
                               input logic [3:0] cond, input logic wr);
    ent_t e;
    logic accept, p;
    in_valid = v; in_y = y; in_nzcv = nzcv; in_rd = rd;
    in_we = we; in_setf = setf; in_cond = cond; wb_ready = wr;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    accept = v && (model_q.size() < DEPTH);
    if (model_q.size() != 0) begin
      p = model_cond(model_q[0].cond, model_flags);
      if (!p || !model_q[0].we || wr) begin
        if (p && model_q[0].we) writes_seen++;
        if (p && model_q[0].setf) model_flags = model_q[0].nzcv;
        void'(model_q.pop_front());
      end
    end
    if (accept) begin
      e = '{y: y, nzcv: nzcv, rd: rd, we: we, setf: setf, cond: cond};
      model_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 4'h0, 5'd0, 1'b0, 1'b0, 4'd14, wr);
  endtask

  initial begin
    model_flags = 4'b0000;
    writes_seen = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_y = '0; in_nzcv = '0; in_rd = '0;
    in_we = 1'b0; in_setf = 1'b0; in_cond = '0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] simple write, AL");
    applyStimulus(1'b1, 32'd5, 4'b0000, 5'd3, 1'b1, 1'b0, 4'd14, 1'b1);
    idle(2, 1'b1);
    checkOutput("t1_writes", W'(writes_seen), W'(1));

    $display("[TB] flag dependency EQ / NE");
    applyStimulus(1'b1, 32'd0, 4'b0100, 5'd0, 1'b0, 1'b1, 4'd14, 1'b1);
    applyStimulus(1'b1, 32'd7, 4'b0000, 5'd1, 1'b1, 1'b0, 4'd0,  1'b1);
    idle(2, 1'b1);
    checkOutput("t2_flags", W'(flags), W'(4'b0100));
    applyStimulus(1'b1, 32'd0, 4'b0100, 5'd0, 1'b0, 1'b1, 4'd14, 1'b1);
    applyStimulus(1'b1, 32'd9, 4'b0000, 5'd1, 1'b1, 1'b0, 4'd1,  1'b1);
    idle(2, 1'b1);
    checkOutput("t2_writes", W'(writes_seen), W'(2));

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'hA1, 4'h0, 5'd4, 1'b1, 1'b0, 4'd14, 1'b0);
    applyStimulus(1'b1, 32'hA2, 4'h0, 5'd5, 1'b1, 1'b0, 4'd14, 1'b0);
    applyStimulus(1'b1, 32'hA3, 4'h0, 5'd6, 1'b1, 1'b0, 4'd14, 1'b0);
    applyStimulus(1'b1, 32'hA3, 4'h0, 5'd6, 1'b1, 1'b0, 4'd14, 1'b0);
    applyStimulus(1'b1, 32'hA3, 4'h0, 5'd6, 1'b1, 1'b1, 4'd14, 1'b1);
    idle(4, 1'b1);

    $display("[TB] NV entry");
    applyStimulus(1'b1, 32'h1, 4'b1111, 5'd2, 1'b1, 1'b1, 4'd15, 1'b0);
    idle(2, 1'b0);
    checkOutput("t4_flags", W'(flags), W'(model_flags));

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 32'h0, 4'b1010, 5'd0, 1'b0, 1'b1, 4'd14, 1'b1);
    applyStimulus(1'b1, 32'hB1, 4'h0, 5'd7, 1'b1, 1'b0, 4'd14, 1'b0);
    applyStimulus(1'b1, 32'hB2, 4'h0, 5'd8, 1'b1, 1'b0, 4'd14, 1'b0);
    in_valid = 1'b0;
    #1;
    checkOutput("pre_rst_wbv", W'(wb_valid), W'(1));
    rst = 1'b1;
    #1;
    model_q.delete();
    model_flags = 4'b0000;
    checkAll();
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b0;
    @(posedge clk); #1;
    idle(3, 1'b1);

    $display("[TB] random stress");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, 4'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 99) < 65));
    end
    idle(6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
